// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard detection unit: stall-length
// encoding, register-number width and the hard-wired zero register.
package hazard_detection_unit_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ONE  = 2'd1;
    localparam logic [1:0] STALL_TWO  = 2'd2;

    // A producer only matters if it writes the register and that register is not $zero.
    function automatic logic reg_match(
        input logic             reg_write,
        input logic [REG_W-1:0] write_reg,
        input logic [REG_W-1:0] src_reg
    );
        return reg_write & (write_reg == src_reg) & (src_reg != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_need_calc.sv
// Combinational stall-length calculation for the instruction in ID against
// the producers currently in EX and MEM.
module hazard_need_calc
    import hazard_detection_unit_pkg::*;
(
    input  logic             id_rs_i,
    input  logic [REG_W-1:0] id_rs_num_i,
    input  logic [REG_W-1:0] id_rt_num_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic             id_jr_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [REG_W-1:0] ex_write_reg_i,
    input  logic             mem_mem_read_i,
    input  logic             mem_reg_write_i,
    input  logic [REG_W-1:0] mem_write_reg_i,
    output logic [1:0]       need_o
);

    logic uses_rt_s;
    logic early_s;
    logic ex_hit_s;
    logic mem_hit_s;

    // Dependence terms; jr never reads Rt whatever the decoder says.
    always_comb begin
        uses_rt_s = id_uses_rt_i & ~id_jr_i;
        early_s   = id_branch_i | id_jr_i;
        ex_hit_s  = (id_rs_i   & reg_match(ex_reg_write_i,  ex_write_reg_i,  id_rs_num_i))
                  | (uses_rt_s & reg_match(ex_reg_write_i,  ex_write_reg_i,  id_rt_num_i));
        mem_hit_s = (id_rs_i   & reg_match(mem_reg_write_i, mem_write_reg_i, id_rs_num_i))
                  | (uses_rt_s & reg_match(mem_reg_write_i, mem_write_reg_i, id_rt_num_i));
    end

    // Highest applicable stall length wins.
    always_comb begin
        need_o = STALL_NONE;
        if (early_s && ex_hit_s && ex_mem_read_i) begin
            need_o = STALL_TWO;
        end else if (early_s && (ex_hit_s || (mem_hit_s && mem_mem_read_i))) begin
            need_o = STALL_ONE;
        end else if (!early_s && ex_hit_s && ex_mem_read_i) begin
            need_o = STALL_ONE;
        end else begin
            need_o = STALL_NONE;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / early-branch hazard detection: drives the ID/EX bubble select and
// the PC / IF-ID write enables, holding multi-cycle stalls with a down-counter.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [REG_W-1:0]       ID_Rs,
    input  logic [REG_W-1:0]       ID_Rt,
    input  logic                   ID_UsesRs,
    input  logic                   ID_UsesRt,
    input  logic                   ID_Branch,
    input  logic                   ID_JRSrc,
    input  logic                   EX_MemRead,
    input  logic                   EX_RegWrite,
    input  logic [REG_W-1:0]       EX_WriteReg,
    input  logic                   MEM_MemRead,
    input  logic                   MEM_RegWrite,
    input  logic [REG_W-1:0]       MEM_WriteReg,
    input  logic                   Flush,
    output logic                   Hazard,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic [STALL_CNT_W-1:0] StallCount
);

    logic [1:0]             need_s;
    logic                   detect_s;
    logic                   stall_s;
    logic [1:0]             cnt_q;
    logic [1:0]             cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    hazard_need_calc u_need_calc (
        .id_rs_i         (ID_UsesRs),
        .id_rs_num_i     (ID_Rs),
        .id_rt_num_i     (ID_Rt),
        .id_uses_rt_i    (ID_UsesRt),
        .id_branch_i     (ID_Branch),
        .id_jr_i         (ID_JRSrc),
        .ex_mem_read_i   (EX_MemRead),
        .ex_reg_write_i  (EX_RegWrite),
        .ex_write_reg_i  (EX_WriteReg),
        .mem_mem_read_i  (MEM_MemRead),
        .mem_reg_write_i (MEM_RegWrite),
        .mem_write_reg_i (MEM_WriteReg),
        .need_o          (need_s)
    );

    // Stall decision and hold-counter next state; a flush discards the held instruction.
    always_comb begin
        detect_s = (cnt_q == 2'd0) && (need_s != STALL_NONE) && !Flush;
        stall_s  = !Flush && (detect_s || (cnt_q != 2'd0));
        cnt_d    = 2'd0;
        if (Flush) begin
            cnt_d = 2'd0;
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end else if (detect_s) begin
            cnt_d = need_s - 2'd1;
        end else begin
            cnt_d = 2'd0;
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q       <= 2'd0;
            stall_cnt_q <= {STALL_CNT_W{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Hazard     = stall_s;
    assign PCWrite    = !stall_s;
    assign IFIDWrite  = !stall_s;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench for hazard_detection_unit (default width plus a
// 3-bit StallCount instance for saturation).
module tb_hazard_detection_unit;

    logic        Clk;
    logic        Rst;
    logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
    logic        ID_UsesRs, ID_UsesRt, ID_Branch, ID_JRSrc;
    logic        EX_MemRead, EX_RegWrite, MEM_MemRead, MEM_RegWrite, Flush;
    logic        Hazard, PCWrite, IFIDWrite;
    logic [31:0] StallCount;
    logic        Hazard3, PCWrite3, IFIDWrite3;
    logic [2:0]  StallCount3;

    int tests_run;
    int tests_failed;

    hazard_detection_unit dut (
        .Clk(Clk), .Rst(Rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_JRSrc(ID_JRSrc),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .MEM_MemRead(MEM_MemRead), .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
        .Flush(Flush),
        .Hazard(Hazard), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .StallCount(StallCount)
    );

    hazard_detection_unit #(.STALL_CNT_W(3)) dut3 (
        .Clk(Clk), .Rst(Rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_JRSrc(ID_JRSrc),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .MEM_MemRead(MEM_MemRead), .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
        .Flush(Flush),
        .Hazard(Hazard3), .PCWrite(PCWrite3), .IFIDWrite(IFIDWrite3), .StallCount(StallCount3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        ID_Branch = 1'b0; ID_JRSrc = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        MEM_MemRead = 1'b0; MEM_RegWrite = 1'b0; MEM_WriteReg = 5'd0;
        Flush = 1'b0;
    endtask

    task automatic set_ex(input logic rd, input logic wr, input logic [4:0] r);
        EX_MemRead = rd; EX_RegWrite = wr; EX_WriteReg = r;
    endtask

    task automatic set_mem(input logic rd, input logic wr, input logic [4:0] r);
        MEM_MemRead = rd; MEM_RegWrite = wr; MEM_WriteReg = r;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic br, input logic jr);
        ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt; ID_Branch = br; ID_JRSrc = jr;
    endtask

    // Drive on the falling edge, sample 1 time unit later, well clear of the rising edge.
    task automatic next_cycle();
        @(negedge Clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        clear_inputs();
        Rst = 1'b0;
        #2;
        chk("reset_hazard", {31'd0, Hazard}, 32'd0);
        chk("reset_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("reset_ifidwrite", {31'd0, IFIDWrite}, 32'd1);
        chk("reset_stallcount", StallCount, 32'd0);
        next_cycle();
        Rst = 1'b1;

        // Load-use: lw $8 in EX, add reading $8 in ID.
        next_cycle();
        set_ex(1'b1, 1'b1, 5'd8); set_id(5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_hazard", {31'd0, Hazard}, 32'd1);
        chk("lu_pcwrite", {31'd0, PCWrite}, 32'd0);
        chk("lu_ifidwrite", {31'd0, IFIDWrite}, 32'd0);
        next_cycle();
        set_ex(1'b0, 1'b0, 5'd0); set_mem(1'b1, 1'b1, 5'd8);
        #1;
        chk("lu_after_hazard", {31'd0, Hazard}, 32'd0);
        chk("lu_after_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("lu_stallcount", StallCount, 32'd1);

        // Branch after load: two stall cycles, second one held by cnt.
        next_cycle();
        clear_inputs();
        set_ex(1'b1, 1'b1, 5'd9); set_id(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("bl_c1_hazard", {31'd0, Hazard}, 32'd1);
        next_cycle();
        set_ex(1'b0, 1'b0, 5'd0); set_mem(1'b1, 1'b1, 5'd9);
        #1;
        chk("bl_c2_hazard", {31'd0, Hazard}, 32'd1);
        chk("bl_c2_cnt", {30'd0, dut.cnt_q}, 32'd1);
        next_cycle();
        set_mem(1'b0, 1'b0, 5'd0);
        #1;
        chk("bl_c3_hazard", {31'd0, Hazard}, 32'd0);
        chk("bl_stallcount", StallCount, 32'd3);

        // bne after addi in EX: one cycle.
        next_cycle();
        clear_inputs();
        set_ex(1'b0, 1'b1, 5'd4); set_id(5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("ba_hazard", {31'd0, Hazard}, 32'd1);
        next_cycle();
        set_ex(1'b0, 1'b0, 5'd0);
        #1;
        chk("ba_after_hazard", {31'd0, Hazard}, 32'd0);
        chk("ba_stallcount", StallCount, 32'd4);

        // jr $31 with lw $31 in MEM: one cycle.
        next_cycle();
        clear_inputs();
        set_mem(1'b1, 1'b1, 5'd31); set_id(5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("jr_mem_hazard", {31'd0, Hazard}, 32'd1);
        next_cycle();
        set_mem(1'b0, 1'b0, 5'd0);
        #1;
        chk("jr_mem_after_hazard", {31'd0, Hazard}, 32'd0);
        chk("jr_mem_stallcount", StallCount, 32'd5);

        // jr ignores Rt even if UsesRt is set.
        next_cycle();
        clear_inputs();
        set_ex(1'b1, 1'b1, 5'd7); set_id(5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("jr_rt_ignored", {31'd0, Hazard}, 32'd0);

        // $zero destination and unused source never stall.
        next_cycle();
        clear_inputs();
        set_ex(1'b1, 1'b1, 5'd0); set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("zero_reg_hazard", {31'd0, Hazard}, 32'd0);
        chk("zero_reg_pcwrite", {31'd0, PCWrite}, 32'd1);
        next_cycle();
        set_ex(1'b1, 1'b1, 5'd5); set_id(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("unused_rs_hazard", {31'd0, Hazard}, 32'd0);
        next_cycle();
        chk("no_stall_count", StallCount, 32'd5);

        // Flush during the second cycle of a two-cycle stall.
        clear_inputs();
        set_ex(1'b1, 1'b1, 5'd9); set_id(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("fl_c1_hazard", {31'd0, Hazard}, 32'd1);
        next_cycle();
        set_ex(1'b0, 1'b0, 5'd0); set_mem(1'b1, 1'b1, 5'd9); Flush = 1'b1;
        #1;
        chk("fl_c2_hazard", {31'd0, Hazard}, 32'd0);
        chk("fl_c2_pcwrite", {31'd0, PCWrite}, 32'd1);
        next_cycle();
        clear_inputs();
        #1;
        chk("fl_cnt_cleared", {30'd0, dut.cnt_q}, 32'd0);
        chk("fl_after_hazard", {31'd0, Hazard}, 32'd0);
        chk("fl_stallcount", StallCount, 32'd6);

        // Flush coinciding with load-use detection.
        next_cycle();
        set_ex(1'b1, 1'b1, 5'd8); set_id(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); Flush = 1'b1;
        #1;
        chk("fl_detect_hazard", {31'd0, Hazard}, 32'd0);
        next_cycle();
        clear_inputs();
        #1;
        chk("fl_detect_cnt", {30'd0, dut.cnt_q}, 32'd0);
        chk("fl_detect_stallcount", StallCount, 32'd6);

        // Asynchronous reset mid-stall with cnt=1.
        next_cycle();
        set_ex(1'b1, 1'b1, 5'd9); set_id(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        clear_inputs();
        #1;
        chk("rst_pre_cnt", {30'd0, dut.cnt_q}, 32'd1);
        chk("rst_pre_hazard", {31'd0, Hazard}, 32'd1);
        Rst = 1'b0;
        #1;
        chk("rst_async_cnt", {30'd0, dut.cnt_q}, 32'd0);
        chk("rst_async_hazard", {31'd0, Hazard}, 32'd0);
        chk("rst_async_stallcount", StallCount, 32'd0);
        next_cycle();
        Rst = 1'b1;

        // Saturation: continuous load-use for 10 edges.
        next_cycle();
        set_ex(1'b1, 1'b1, 5'd8); set_id(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) next_cycle();
        #1;
        chk("sat7_count3", {29'd0, StallCount3}, 32'd7);
        chk("sat_hold_hazard", {31'd0, Hazard3}, 32'd1);
        for (int i = 0; i < 3; i++) next_cycle();
        #1;
        chk("sat10_count3", {29'd0, StallCount3}, 32'd7);
        chk("sat10_count32", StallCount, 32'd10);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
